// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Holds the datapath sizes, IR field positions, opcode encodings,
// the sequencer state encoding and the ALU select bundle.
package cpu_ctrl_pkg;

   localparam int BITS      = 32;
   localparam int REGISTERS = 16;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   typedef logic [4:0] opcode_t;

   localparam opcode_t OP_ADD    = 5'b00011;
   localparam opcode_t OP_SUB    = 5'b00100;
   localparam opcode_t OP_SHR    = 5'b00101;
   localparam opcode_t OP_SHL    = 5'b00110;
   localparam opcode_t OP_ROR    = 5'b00111;
   localparam opcode_t OP_ROL    = 5'b01000;
   localparam opcode_t OP_AND    = 5'b01001;
   localparam opcode_t OP_OR     = 5'b01010;
   localparam opcode_t OP_MUL    = 5'b01110;
   localparam opcode_t OP_DIV    = 5'b01111;
   localparam opcode_t OP_NEGATE = 5'b10000;
   localparam opcode_t OP_NOT    = 5'b10001;

   // T0..T5 take the natural 3-bit codes; IDLE and HALT use the two spare codes.
   typedef enum logic [2:0] {
      ST_T0   = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T3   = 3'd3,
      ST_T4   = 3'd4,
      ST_T5   = 3'd5,
      ST_IDLE = 3'd6,
      ST_HALT = 3'd7
   } state_t;

   // Field order matches the strobe order ADD..NOT used by the top level.
   typedef struct packed {
      logic add;
      logic sub;
      logic mul;
      logic div;
      logic shr;
      logic shl;
      logic ror;
      logic rol;
      logic and_op;
      logic or_op;
      logic negate;
      logic not_op;
   } alu_sel_t;

   function automatic logic [REGISTERS-1:0] reg_onehot(input logic [3:0] idx);
      logic [REGISTERS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Strobe bus between the control sequencer and the datapath.
// master: sequencer side (drives strobes, receives run/mem_ready/IRVal).
// slave : datapath/environment side.
interface control_unit_if;
   import cpu_ctrl_pkg::*;

   logic                 run;
   logic                 mem_ready;
   logic [BITS-1:0]      IRVal;

   logic                 PCout, MARin, IncPC, RZin, RZout, PCin;
   logic                 Read, MDRin, MDRout, IRin, RYin, HILOin;
   logic [REGISTERS-1:0] GPRin, GPRout;
   logic                 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL;
   logic                 AND, OR, NEGATE, NOT;
   logic                 halted, illegal;

   modport master (
      input  run, mem_ready, IRVal,
      output PCout, MARin, IncPC, RZin, RZout, PCin,
      output Read, MDRin, MDRout, IRin, RYin, HILOin,
      output GPRin, GPRout,
      output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
      output halted, illegal
   );

   modport slave (
      output run, mem_ready, IRVal,
      input  PCout, MARin, IncPC, RZin, RZout, PCin,
      input  Read, MDRin, MDRout, IRin, RYin, HILOin,
      input  GPRin, GPRout,
      input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
      input  halted, illegal
   );

endinterface

// File: rtl/ir_decode.sv
// Combinational instruction decode.
// Ports:
//   ir_val     in   instruction register contents
//   is_binary  out  two-operand op (Rb, Rc), includes MUL/DIV
//   is_unary   out  NEGATE/NOT (Rb only)
//   is_muldiv  out  MUL/DIV, result goes to HI/LO
//   is_illegal out  opcode not in the supported set
//   alu_sel    out  one-hot ALU select (all zero when illegal)
//   ra_oh/rb_oh/rc_oh out  one-hot register selects from the IR fields
module ir_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [BITS-1:0]      ir_val,
   output logic                 is_binary,
   output logic                 is_unary,
   output logic                 is_muldiv,
   output logic                 is_illegal,
   output alu_sel_t             alu_sel,
   output logic [REGISTERS-1:0] ra_oh,
   output logic [REGISTERS-1:0] rb_oh,
   output logic [REGISTERS-1:0] rc_oh
);

   opcode_t opcode;
   logic    unused_low_bits;

   assign opcode          = ir_val[OP_MSB:OP_LSB];
   assign unused_low_bits = ^ir_val[RC_LSB-1:0];

   assign ra_oh = reg_onehot(ir_val[RA_MSB:RA_LSB]);
   assign rb_oh = reg_onehot(ir_val[RB_MSB:RB_LSB]);
   assign rc_oh = reg_onehot(ir_val[RC_MSB:RC_LSB]);

   always_comb begin
      alu_sel    = '0;
      is_binary  = 1'b1;
      is_unary   = 1'b0;
      is_muldiv  = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OP_ADD:    alu_sel.add    = 1'b1;
         OP_SUB:    alu_sel.sub    = 1'b1;
         OP_SHR:    alu_sel.shr    = 1'b1;
         OP_SHL:    alu_sel.shl    = 1'b1;
         OP_ROR:    alu_sel.ror    = 1'b1;
         OP_ROL:    alu_sel.rol    = 1'b1;
         OP_AND:    alu_sel.and_op = 1'b1;
         OP_OR:     alu_sel.or_op  = 1'b1;
         OP_MUL: begin
            alu_sel.mul = 1'b1;
            is_muldiv   = 1'b1;
         end
         OP_DIV: begin
            alu_sel.div = 1'b1;
            is_muldiv   = 1'b1;
         end
         OP_NEGATE: begin
            alu_sel.negate = 1'b1;
            is_binary      = 1'b0;
            is_unary       = 1'b1;
         end
         OP_NOT: begin
            alu_sel.not_op = 1'b1;
            is_binary      = 1'b0;
            is_unary       = 1'b1;
         end
         default: begin
            is_binary  = 1'b0;
            is_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the register-to-register datapath.
// Each instruction: fetch T0-T2 (stalling in T1 on mem_ready), then
// execute T3-T5 decoded from IRVal. Illegal opcodes park the FSM in HALT.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   bus    control_unit_if.master: run/mem_ready/IRVal in, all strobes out
//
// state | meaning
// IDLE  | waiting for run, no strobes
// T0    | PC -> MAR, RZ <= PC+1
// T1    | memory read; wait for mem_ready, then RZ -> PC
// T2    | MDR -> IR
// T3    | decode; Rb -> RY for ops that use RY
// T4    | ALU op into RZ
// T5    | write back RZ to Ra, or RZ to HI/LO for MUL/DIV
// HALT  | illegal opcode seen; only reset leaves
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   control_unit_if.master bus
);

   state_t               state;
   logic                 illegal_q;

   logic                 is_binary;
   logic                 is_unary;
   logic                 is_muldiv;
   logic                 is_illegal;
   alu_sel_t             alu_sel;
   logic [REGISTERS-1:0] ra_oh;
   logic [REGISTERS-1:0] rb_oh;
   logic [REGISTERS-1:0] rc_oh;

   ir_decode u_ir_decode (
      .ir_val     (bus.IRVal),
      .is_binary  (is_binary),
      .is_unary   (is_unary),
      .is_muldiv  (is_muldiv),
      .is_illegal (is_illegal),
      .alu_sel    (alu_sel),
      .ra_oh      (ra_oh),
      .rb_oh      (rb_oh),
      .rc_oh      (rc_oh)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (bus.run) state <= ST_T0;
            ST_T0:   state <= ST_T1;
            ST_T1:   if (bus.mem_ready) state <= ST_T2;
            ST_T2:   state <= ST_T3;
            ST_T3: begin
               if (is_illegal) begin
                  state     <= ST_HALT;
                  illegal_q <= 1'b1;
               end else begin
                  state <= ST_T4;
               end
            end
            ST_T4:   state <= ST_T5;
            ST_T5:   state <= bus.run ? ST_T0 : ST_IDLE;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strobes depend on state and on the IR the datapath currently holds,
   // so T3 already sees the instruction loaded at the end of T2.
   always_comb begin
      bus.PCout  = 1'b0;
      bus.MARin  = 1'b0;
      bus.IncPC  = 1'b0;
      bus.RZin   = 1'b0;
      bus.RZout  = 1'b0;
      bus.PCin   = 1'b0;
      bus.Read   = 1'b0;
      bus.MDRin  = 1'b0;
      bus.MDRout = 1'b0;
      bus.IRin   = 1'b0;
      bus.RYin   = 1'b0;
      bus.HILOin = 1'b0;
      bus.GPRin  = '0;
      bus.GPRout = '0;
      {bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR, bus.SHL,
       bus.ROR, bus.ROL, bus.AND, bus.OR, bus.NEGATE, bus.NOT} = '0;
      bus.halted  = 1'b0;
      bus.illegal = illegal_q;
      case (state)
         ST_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.RZin  = 1'b1;
         end
         ST_T1: begin
            bus.RZout = 1'b1;
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
            // PC is loaded only on the cycle the read completes.
            bus.PCin  = bus.mem_ready;
         end
         ST_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         ST_T3: begin
            if (is_binary) begin
               bus.GPRout = rb_oh;
               bus.RYin   = 1'b1;
            end
         end
         ST_T4: begin
            bus.RZin = 1'b1;
            {bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR, bus.SHL,
             bus.ROR, bus.ROL, bus.AND, bus.OR, bus.NEGATE, bus.NOT} = alu_sel;
            if (is_binary) begin
               bus.GPRout = rc_oh;
            end else if (is_unary) begin
               bus.GPRout = rb_oh;
            end
         end
         ST_T5: begin
            if (is_muldiv) begin
               bus.HILOin = 1'b1;
            end else begin
               bus.RZout = 1'b1;
               bus.GPRin = ra_oh;
            end
         end
         ST_HALT: bus.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
   import cpu_ctrl_pkg::*;

   logic clk;
   logic reset;

   control_unit_if cu ();

   control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (cu.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Opcode table; entry k corresponds to ALU select bit 11-k (ADD first .. NOT last).
   localparam logic [4:0] OPS [12] = '{5'b00011, 5'b00100, 5'b01110, 5'b01111,
                                       5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                       5'b01001, 5'b01010, 5'b10000, 5'b10001};

   function automatic logic [11:0] sel_of(input logic [4:0] op);
      for (int k = 0; k < 12; k++) if (OPS[k] == op) return 12'b1 << (11 - k);
      return 12'b0;
   endfunction

   function automatic logic [4:0] op_of_sel(input logic [11:0] sel);
      for (int k = 0; k < 12; k++) if (sel == (12'b1 << (11 - k))) return OPS[k];
      return 5'b0;
   endfunction

   function automatic logic [3:0] oh_idx(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
      return 4'd0;
   endfunction

   // ISA semantics: {HI,LO} for MUL/DIV, low word otherwise.
   function automatic logic [63:0] isa_op(input logic [4:0] op, input logic [31:0] b,
                                          input logic [31:0] c);
      logic [4:0] s;
      s = c[4:0];
      case (op)
         5'b00011: return {32'b0, b + c};
         5'b00100: return {32'b0, b - c};
         5'b00101: return {32'b0, b >> s};
         5'b00110: return {32'b0, b << s};
         5'b00111: return {32'b0, (b >> s) | (b << (6'd32 - {1'b0, s}))};
         5'b01000: return {32'b0, (b << s) | (b >> (6'd32 - {1'b0, s}))};
         5'b01001: return {32'b0, b & c};
         5'b01010: return {32'b0, b | c};
         5'b01110: return 64'(b) * 64'(c);
         5'b01111: return (c == 0) ? 64'b0 : {b % c, b / c};
         5'b10000: return {32'b0, -b};
         5'b10001: return {32'b0, ~b};
         default:  return 64'b0;
      endcase
   endfunction

   // ---------------- behavioural datapath driven by the strobes ----------------
   logic [31:0] pc  = '0;
   logic [31:0] mar = '0;
   logic [31:0] mdr = '0;
   logic [31:0] ir  = '0;
   logic [31:0] ry  = '0;
   logic [31:0] hi  = '0;
   logic [31:0] lo  = '0;
   logic [63:0] rz  = '0;
   logic [31:0] dp_r [16];
   logic [31:0] mem  [256];
   int          gpr_writes = 0;
   logic        poke_en  = 1'b0;
   logic [3:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;
   logic [31:0] bus_v;
   logic [11:0] alu_v;
   logic [57:0] outs;

   assign cu.IRVal = ir;
   assign alu_v = {cu.ADD, cu.SUB, cu.MUL, cu.DIV, cu.SHR, cu.SHL,
                   cu.ROR, cu.ROL, cu.AND, cu.OR, cu.NEGATE, cu.NOT};
   assign outs  = {cu.PCout, cu.MARin, cu.IncPC, cu.RZin, cu.RZout, cu.PCin,
                   cu.Read, cu.MDRin, cu.MDRout, cu.IRin, cu.RYin, cu.HILOin,
                   cu.GPRin, cu.GPRout, alu_v, cu.halted, cu.illegal};

   always_comb begin
      bus_v = '0;
      if (cu.PCout)        bus_v = pc;
      else if (cu.RZout)   bus_v = rz[31:0];
      else if (cu.MDRout)  bus_v = mdr;
      else if (|cu.GPRout) bus_v = dp_r[oh_idx(cu.GPRout)];
   end

   function automatic logic [63:0] alu_model(input logic [11:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [4:0] op;
      op = op_of_sel(sel);
      if (op == 5'b10000 || op == 5'b10001) return isa_op(op, b, 32'b0);
      return isa_op(op, a, b);
   endfunction

   always @(posedge clk) begin
      if (cu.MARin) mar <= bus_v;
      if (cu.RZin)  rz  <= cu.IncPC ? {32'b0, bus_v + 32'd1} : alu_model(alu_v, ry, bus_v);
      if (cu.PCin)  pc  <= bus_v;
      if (cu.MDRin && cu.Read && cu.mem_ready) mdr <= mem[mar[7:0]];
      if (cu.IRin)  ir  <= bus_v;
      if (cu.RYin)  ry  <= bus_v;
      if (|cu.GPRin) begin
         dp_r[oh_idx(cu.GPRin)] <= bus_v;
         gpr_writes <= gpr_writes + 1;
      end
      if (cu.HILOin) begin
         hi <= rz[63:32];
         lo <= rz[31:0];
      end
      if (poke_en) dp_r[poke_idx] <= poke_val;
   end

   // ---------------- ISA-level reference state ----------------
   logic [31:0] ref_r [16];
   logic [31:0] ref_hi = '0;
   logic [31:0] ref_lo = '0;
   logic [31:0] pc_ref = '0;

   task automatic set_reg(input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_idx = idx;
      poke_val = val;
      ref_r[idx] = val;
      @(negedge clk);
      poke_en = 1'b0;
      #1;
   endtask

   task automatic wait_t0();
      int n;
      n = 0;
      while (!cu.PCout && n < 20) begin
         @(negedge clk);
         cu.mem_ready = 1'($urandom);
         #1;
         n++;
      end
      check_eq("t0_reached", 64'(cu.PCout), 64'(1));
   endtask

   // Runs one legal instruction from IDLE or T0; ends #1 after the negedge
   // following T5 (in T0 if keep_run, else IDLE).
   task automatic exec_instr(input logic [31:0] instr, input int stalls, input bit keep_run);
      logic [4:0]  op;
      logic [3:0]  ra, rb, rc;
      bit          unary, muldiv;
      logic [63:0] res;
      int          mism;
      op = instr[31:27];
      ra = instr[26:23];
      rb = instr[22:19];
      rc = instr[18:15];
      unary  = (op == 5'b10000) || (op == 5'b10001);
      muldiv = (op == 5'b01110) || (op == 5'b01111);
      res = unary ? isa_op(op, ref_r[rb], 32'b0) : isa_op(op, ref_r[rb], ref_r[rc]);
      mem[pc_ref[7:0]] = instr;
      cu.run = 1'b1;
      wait_t0();
      if (!keep_run) cu.run = 1'b0;
      check_eq("t0_strobes", 64'({cu.MARin, cu.IncPC, cu.RZin, cu.RZout, cu.Read, cu.PCin}),
               64'(6'b111000));
      for (int k = 0; k <= stalls; k++) begin
         @(negedge clk);
         cu.mem_ready = (k == stalls);
         #1;
         check_eq("t1_strobes", 64'({cu.RZout, cu.Read, cu.MDRin, cu.PCin, cu.PCout}),
                  64'({3'b111, k == stalls, 1'b0}));
      end
      @(negedge clk); cu.mem_ready = 1'($urandom); #1;
      check_eq("t2_strobes", 64'({cu.MDRout, cu.IRin, cu.Read, cu.PCin}), 64'(4'b1100));
      @(negedge clk); cu.mem_ready = 1'($urandom); #1;
      check_eq("t3_gprout", 64'(cu.GPRout), unary ? 64'(0) : 64'(reg_onehot(rb)));
      check_eq("t3_ryin", 64'(cu.RYin), 64'(!unary));
      @(negedge clk); cu.mem_ready = 1'($urandom); #1;
      check_eq("t4_gprout", 64'(cu.GPRout), 64'(reg_onehot(unary ? rb : rc)));
      check_eq("t4_alu", 64'({alu_v, cu.RZin}), 64'({sel_of(op), 1'b1}));
      @(negedge clk); cu.mem_ready = 1'($urandom); #1;
      check_eq("t5_wb", 64'({cu.GPRin, cu.HILOin, cu.RZout}),
               muldiv ? 64'({16'b0, 2'b10}) : 64'({reg_onehot(ra), 2'b01}));
      @(negedge clk); cu.mem_ready = 1'($urandom); #1;
      if (keep_run) check_eq("next_t0", 64'(cu.PCout), 64'(1));
      else          check_eq("idle_after", 64'(outs), 64'(0));
      if (muldiv) begin
         ref_hi = res[63:32];
         ref_lo = res[31:0];
         check_eq("hilo", {hi, lo}, res);
      end else begin
         ref_r[ra] = res[31:0];
         check_eq("result", 64'(dp_r[ra]), 64'(res[31:0]));
      end
      pc_ref = pc_ref + 1;
      check_eq("pc_once", 64'(pc), 64'(pc_ref));
      mism = 0;
      for (int i = 0; i < 16; i++) if (dp_r[i] !== ref_r[i]) mism++;
      check_eq("gpr_file", 64'(mism), 64'(0));
   endtask

   initial begin
      logic [31:0] instr;
      logic [4:0]  op;
      logic [3:0]  ra, rb, rc;
      logic [31:0] r5_before;
      int          gw;

      reset = 1'b1;
      cu.run = 1'b0;
      cu.mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_outs", 64'(outs), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("post_reset_outs", 64'(outs), 64'(0));

      for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom | 32'd1);
      set_reg(4'd2, 32'd13);
      set_reg(4'd4, 32'd4);
      set_reg(4'd5, 32'h55);

      // AND R5,R2,R4 then ADD R5,R2,R4 with run dropped mid-instruction
      exec_instr(32'h4A92_0000, 0, 1'b1);
      check_eq("and_r5", 64'(dp_r[5]), 64'(4));
      exec_instr(32'h1A92_0000, 0, 1'b0);
      check_eq("add_r5", 64'(dp_r[5]), 64'(17));

      // MUL R2,R4
      exec_instr({5'b01110, 4'd0, 4'd2, 4'd4, 15'd0}, 0, 1'b1);
      check_eq("mul_lo", 64'(lo), 64'(52));
      check_eq("mul_hi", 64'(hi), 64'(0));

      // three-cycle memory stall
      exec_instr(32'h1A92_0000, 3, 1'b1);

      for (int t = 0; t < 40; t++) begin
         op = OPS[$urandom_range(0, 11)];
         ra = 4'($urandom);
         rb = 4'($urandom);
         rc = 4'($urandom);
         if (op == 5'b01111 && ref_r[rc] == 32'd0) op = 5'b00011;
         instr = {op, ra, rb, rc, 15'($urandom)};
         exec_instr(instr, $urandom_range(0, 3), (t != 39) && ($urandom_range(0, 3) != 0));
      end

      // illegal opcode
      gw = gpr_writes;
      mem[pc_ref[7:0]] = 32'hF800_0000;
      cu.run = 1'b1;
      wait_t0();
      @(negedge clk); cu.mem_ready = 1'b1; #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      check_eq("t3_illegal_quiet", 64'(outs), 64'(0));
      @(negedge clk); #1;
      check_eq("halt_entered", 64'(outs), 64'(2'b11));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         cu.run = 1'($urandom);
         cu.mem_ready = 1'($urandom);
         #1;
      end
      check_eq("halt_sticky", 64'(outs), 64'(2'b11));
      check_eq("halt_no_gprin", 64'(gpr_writes), 64'(gw));
      pc_ref = pc_ref + 1;

      reset = 1'b1;
      #1;
      check_eq("reset_clears_halt", 64'(outs), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      cu.run = 1'b0;
      #1;

      // reset in T4 of an ADD
      r5_before = dp_r[5];
      mem[pc_ref[7:0]] = 32'h1A92_0000;
      cu.run = 1'b1;
      wait_t0();
      @(negedge clk); cu.mem_ready = 1'b1; #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      check_eq("t4_before_reset", 64'(cu.RZin), 64'(1));
      reset = 1'b1;
      #1;
      check_eq("reset_mid_t4", 64'(outs), 64'(0));
      repeat (2) @(negedge clk);
      #1;
      check_eq("r5_unchanged", 64'(dp_r[5]), 64'(r5_before));
      pc_ref = pc_ref + 1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("release_idle", 64'(outs), 64'(0));
      @(negedge clk); #1;
      check_eq("restart_t0", 64'(cu.PCout), 64'(1));
      exec_instr(32'h1A92_0000, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
